// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); one request in flight, completed on req && ready.
interface fetch_stage_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over the imem handshake, registers the IF/ID slot.
// Optional FETCH_STATS_EN adds Fetch_Cnt / Bubble_Cnt delivery counters.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// REQ   | request outstanding at imem_addr
// HOLD  | response parked in skid buffer while ID is frozen, no request
module fetch_stage #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Freeze,
    input  logic            Branch_Taken,
    input  logic [PC_W-1:0] Branch_Addr,
    fetch_stage_if.master   imem,
    output logic [PC_W-1:0] PC_Out,
    output logic [31:0]     Instruction_Out,
`ifdef FETCH_STATS_EN
    output logic [31:0]     Fetch_Cnt,
    output logic [31:0]     Bubble_Cnt,
`endif
    output logic            Valid_Out
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic            kill_q;
    logic [PC_W-1:0] kill_addr_q;
    logic [PC_W-1:0] skid_pc_q;
    logic [31:0]     skid_instr_q;

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_tgt;
    logic            accept;
    logic            live_accept;
    logic            load_fetch;
    logic            load_skid_out;
    logic            load_bubble;
    logic            set_kill;

    assign pc_plus4    = pc_q + PC_W'(4);
    assign branch_tgt  = Branch_Addr & ~PC_W'(3);
    assign accept      = imem.imem_req && imem.imem_ready;
    // a response counts only if it belongs to the current PC and no redirect lands now
    assign live_accept = accept && !kill_q && !Branch_Taken;
    assign set_kill    = Branch_Taken && imem.imem_req && !imem.imem_ready;

    assign load_fetch    = (state_q == REQ) && live_accept && !Freeze;
    assign load_skid_out = (state_q == HOLD) && !Branch_Taken && !Freeze;
    assign load_bubble   = Branch_Taken || ((state_q == REQ) && !Freeze && !live_accept);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (live_accept && Freeze) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Branch_Taken || !Freeze) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a killed request keeps presenting its original address until accepted
    always_comb begin
        imem.imem_req  = (state_q == REQ);
        imem.imem_addr = kill_q ? kill_addr_q : pc_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            kill_addr_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            if (Branch_Taken) begin
                pc_q <= branch_tgt;
            end else if (live_accept) begin
                pc_q <= pc_plus4;
            end

            if (set_kill) begin
                kill_q <= 1'b1;
                if (!kill_q) begin
                    kill_addr_q <= pc_q;
                end
            end else if (accept) begin
                kill_q <= 1'b0;
            end

            if ((state_q == REQ) && live_accept && Freeze) begin
                skid_pc_q    <= pc_plus4;
                skid_instr_q <= imem.imem_rdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PC_Out          <= '0;
            Instruction_Out <= NOP_INSTR;
            Valid_Out       <= 1'b0;
        end else if (load_fetch) begin
            PC_Out          <= pc_plus4;
            Instruction_Out <= imem.imem_rdata;
            Valid_Out       <= 1'b1;
        end else if (load_skid_out) begin
            PC_Out          <= skid_pc_q;
            Instruction_Out <= skid_instr_q;
            Valid_Out       <= 1'b1;
        end else if (load_bubble) begin
            Instruction_Out <= NOP_INSTR;
            Valid_Out       <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Fetch_Cnt  <= '0;
            Bubble_Cnt <= '0;
        end else begin
            if (load_fetch || load_skid_out) begin
                Fetch_Cnt <= Fetch_Cnt + 32'd1;
            end
            if (load_bubble && !Freeze) begin
                Bubble_Cnt <= Bubble_Cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, freeze/skid, branch kill, PC wrap, async reset.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        Freeze;
    logic        Branch_Taken;
    logic [31:0] Branch_Addr;
    logic [31:0] PC_Out;
    logic [31:0] Instruction_Out;
    logic        Valid_Out;
`ifdef FETCH_STATS_EN
    logic [31:0] Fetch_Cnt;
    logic [31:0] Bubble_Cnt;
    logic [31:0] fetch_before;
`endif

    int tests_run;
    int tests_failed;

    fetch_stage_if #(.PC_W(32)) imem_bus ();

    fetch_stage #(
        .PC_W      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .Freeze          (Freeze),
        .Branch_Taken    (Branch_Taken),
        .Branch_Addr     (Branch_Addr),
        .imem            (imem_bus.master),
        .PC_Out          (PC_Out),
        .Instruction_Out (Instruction_Out),
`ifdef FETCH_STATS_EN
        .Fetch_Cnt       (Fetch_Cnt),
        .Bubble_Cnt      (Bubble_Cnt),
`endif
        .Valid_Out       (Valid_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE3A0_1005 + a;
    endfunction

    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        RST                 = 1'b0;
        Freeze              = 1'b0;
        Branch_Taken        = 1'b0;
        Branch_Addr         = 32'h0;
        imem_bus.imem_ready = 1'b1;

        repeat (2) step();
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_valid", 32'(Valid_Out), 32'd0);
        check("rst_pc_out", PC_Out, 32'h0);
        check("rst_instr", Instruction_Out, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_fetch_cnt", Fetch_Cnt, 32'h0);
`endif

        RST = 1'b1;
        check("idle_req", 32'(imem_bus.imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_bus.imem_req), 32'd1);
        check("first_addr", imem_bus.imem_addr, 32'h0);
        step();
        check("first_pc_out", PC_Out, 32'h4);
        check("first_valid", 32'(Valid_Out), 32'd1);
        check("first_instr", Instruction_Out, 32'hE3A0_1005);
        check("addr_4", imem_bus.imem_addr, 32'h4);
        step();
        check("pc_out_8", PC_Out, 32'h8);
        check("addr_8", imem_bus.imem_addr, 32'h8);

        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_valid", 32'(Valid_Out), 32'd0);
            check("wait_addr", imem_bus.imem_addr, 32'h8);
            check("wait_pc_out", PC_Out, 32'h8);
        end
        imem_bus.imem_ready = 1'b1;
        step();
        check("after_wait_pc_out", PC_Out, 32'hC);
        check("after_wait_instr", Instruction_Out, mem_word(32'h8));
        check("after_wait_valid", 32'(Valid_Out), 32'd1);
        step();
        check("addr_10", imem_bus.imem_addr, 32'h10);

        Freeze = 1'b1;
        step();
        check("frz1_req", 32'(imem_bus.imem_req), 32'd0);
        check("frz1_pc_out", PC_Out, 32'h10);
        check("frz1_instr", Instruction_Out, mem_word(32'hC));
        step();
        check("frz2_req", 32'(imem_bus.imem_req), 32'd0);
        check("frz2_pc_out", PC_Out, 32'h10);
        check("frz2_valid", 32'(Valid_Out), 32'd1);
        Freeze = 1'b0;
        step();
        check("skid_pc_out", PC_Out, 32'h14);
        check("skid_instr", Instruction_Out, mem_word(32'h10));
        check("skid_valid", 32'(Valid_Out), 32'd1);
        check("skid_next_addr", imem_bus.imem_addr, 32'h14);
        repeat (3) step();
        check("addr_20", imem_bus.imem_addr, 32'h20);

        imem_bus.imem_ready = 1'b0;
        Branch_Taken        = 1'b1;
        Branch_Addr         = 32'h0000_0103;
        step();
        Branch_Taken = 1'b0;
        check("br_flush_valid", 32'(Valid_Out), 32'd0);
        check("br_flush_instr", Instruction_Out, 32'h0);
        check("br_kill_addr", imem_bus.imem_addr, 32'h20);
        step();
        check("br_kill_addr2", imem_bus.imem_addr, 32'h20);
        imem_bus.imem_ready = 1'b1;
        step();
        check("br_discard_valid", 32'(Valid_Out), 32'd0);
        check("br_discard_pc_out", PC_Out, 32'h20);
        check("br_target_addr", imem_bus.imem_addr, 32'h100);
        step();
        check("br_pc_out", PC_Out, 32'h104);
        check("br_instr", Instruction_Out, mem_word(32'h100));

        Freeze = 1'b1;
        step();
        check("hold_req", 32'(imem_bus.imem_req), 32'd0);
        check("hold_pc_out", PC_Out, 32'h104);
        Branch_Taken = 1'b1;
        Branch_Addr  = 32'h0000_0200;
        step();
        Branch_Taken = 1'b0;
        Freeze       = 1'b0;
        check("hold_br_valid", 32'(Valid_Out), 32'd0);
        check("hold_br_req", 32'(imem_bus.imem_req), 32'd1);
        check("hold_br_addr", imem_bus.imem_addr, 32'h200);
        step();
        check("hold_br_pc_out", PC_Out, 32'h204);
        check("hold_br_instr", Instruction_Out, mem_word(32'h200));

        Branch_Taken = 1'b1;
        Branch_Addr  = 32'hFFFF_FFFC;
        step();
        Branch_Taken = 1'b0;
        check("same_cyc_br_valid", 32'(Valid_Out), 32'd0);
        check("same_cyc_br_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_STATS_EN
        fetch_before = Fetch_Cnt;
`endif
        step();
        check("wrap_pc_out", PC_Out, 32'h0);
        check("wrap_instr", Instruction_Out, 32'hE3A0_1001);
        check("wrap_valid", 32'(Valid_Out), 32'd1);
        check("wrap_addr", imem_bus.imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
        check("wrap_fetch_cnt", Fetch_Cnt, fetch_before + 32'd1);
`endif

        imem_bus.imem_ready = 1'b0;
        Branch_Taken        = 1'b1;
        Branch_Addr         = 32'h0000_0300;
        step();
        check("rebr1_addr", imem_bus.imem_addr, 32'h0);
        Branch_Addr = 32'h0000_0400;
        step();
        Branch_Taken = 1'b0;
        check("rebr2_addr", imem_bus.imem_addr, 32'h0);
        check("rebr2_valid", 32'(Valid_Out), 32'd0);
        imem_bus.imem_ready = 1'b1;
        step();
        check("rebr_discard_valid", 32'(Valid_Out), 32'd0);
        check("rebr_target_addr", imem_bus.imem_addr, 32'h400);
        step();
        check("rebr_pc_out", PC_Out, 32'h404);
        check("rebr_instr", Instruction_Out, mem_word(32'h400));

        imem_bus.imem_ready = 1'b0;
        step();
        check("pre_rst_req", 32'(imem_bus.imem_req), 32'd1);
        RST = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("async_rst_valid", 32'(Valid_Out), 32'd0);
        check("async_rst_pc_out", PC_Out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
